// File: rtl/game_pkg.sv
// Shared game state encoding, screen geometry and sprite ROM addressing
// constants for the game compositor.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } game_state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ROW_W    = 6;
  localparam int COL_W    = 5;
  localparam int SEL_W    = 5;

  localparam logic [SEL_W-1:0] ROM_SEL_DEAD = 5'd31;

  function automatic logic in_active(input logic [9:0] h, input logic [9:0] v);
    return (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
  endfunction

endpackage

// File: rtl/box_hit.sv
// Point-in-box test for one sprite plus the row/col offset into its image.
module box_hit
  import game_pkg::*;
#(
  parameter int BOX_W = 32,
  parameter int BOX_H = 48
) (
  input  logic [9:0]       haddress,
  input  logic [9:0]       vaddress,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  output logic             hit,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);

  logic [10:0] dh;
  logic [10:0] dv;

  // A scan position left of / above the box yields a difference >= 1025,
  // so the single unsigned compare rejects it without any wrap artefact.
  assign dh  = {1'b0, haddress} - {1'b0, pos_x};
  assign dv  = {1'b0, vaddress} - {1'b0, pos_y};
  assign hit = (dh < 11'(BOX_W)) && (dv < 11'(BOX_H));
  assign col = dh[COL_W-1:0];
  assign row = dv[ROW_W-1:0];

endmodule

// File: rtl/game_compositor.sv
// Two-stage sprite compositor: stage 1 resolves hit boxes and ROM address,
// stage 2 merges ROM data with the overlay and tracks collisions and game state.
module game_compositor
  import game_pkg::*;
#(
  parameter int N_OBJ = 8,
  parameter int SPR_W = 32,
  parameter int SPR_H = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         haddress,
  input  logic [9:0]         vaddress,
  input  logic [3:0]         btn,
  input  logic               debug,
  input  logic [9:0]         player_x,
  input  logic [9:0]         player_y,
  input  logic [N_OBJ*10-1:0] obj_x,
  input  logic [N_OBJ*10-1:0] obj_y,
  input  logic [N_OBJ-1:0]   obj_en,
  output logic [5:0]         rom_row,
  output logic [4:0]         rom_col,
  output logic [4:0]         rom_sel,
  input  logic               rom_pix_p,
  input  logic               rom_pix_o,
  input  logic               overlay_pix,
  output logic               pixel,
  output logic [1:0]         game_state,
  output logic               collide,
  output logic [N_OBJ-1:0]   obj_hit
);

  game_state_t state, state_nxt;

  logic             pl_hit;
  logic [ROW_W-1:0] pl_row;
  logic [COL_W-1:0] pl_col;
  logic [N_OBJ-1:0] ob_hit;
  logic [ROW_W-1:0] ob_row [N_OBJ];
  logic [COL_W-1:0] ob_col [N_OBJ];

  logic             win_any;
  logic [N_OBJ-1:0] win_oh;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic [SEL_W-1:0] win_sel;

  logic             vld_p1, act_p1, pl_in_p1, ob_in_p1;
  logic [N_OBJ-1:0] win_oh_p1;

  logic btn_any_q, btn_rise, frame_end, dead_clear, hit_p2, pix_c;

  assign game_state = state;

  box_hit #(.BOX_W(SPR_W), .BOX_H(SPR_H)) u_player (
    .haddress (haddress),
    .vaddress (vaddress),
    .pos_x    (player_x),
    .pos_y    (player_y),
    .hit      (pl_hit),
    .row      (pl_row),
    .col      (pl_col)
  );

  for (genvar k = 0; k < N_OBJ; k++) begin : g_obj
    box_hit #(.BOX_W(SPR_W), .BOX_H(SPR_H)) u_obj (
      .haddress (haddress),
      .vaddress (vaddress),
      .pos_x    (obj_x[k*10 +: 10]),
      .pos_y    (obj_y[k*10 +: 10]),
      .hit      (ob_hit[k]),
      .row      (ob_row[k]),
      .col      (ob_col[k])
    );
  end

  // Descending scan so the lowest enabled overlapping channel wins.
  always_comb begin
    win_any = 1'b0;
    win_oh  = '0;
    win_row = '0;
    win_col = '0;
    win_sel = '0;
    for (int k = N_OBJ - 1; k >= 0; k--) begin
      if (obj_en[k] && ob_hit[k]) begin
        win_any   = 1'b1;
        win_oh    = '0;
        win_oh[k] = 1'b1;
        win_row   = ob_row[k];
        win_col   = ob_col[k];
        win_sel   = SEL_W'(k + 1);
      end
    end
  end

  // Stage 1: hit flags and sprite ROM address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      act_p1    <= 1'b0;
      pl_in_p1  <= 1'b0;
      ob_in_p1  <= 1'b0;
      win_oh_p1 <= '0;
      rom_row   <= '0;
      rom_col   <= '0;
      rom_sel   <= '0;
    end else begin
      vld_p1    <= 1'b1;
      act_p1    <= in_active(haddress, vaddress);
      pl_in_p1  <= pl_hit;
      ob_in_p1  <= win_any;
      win_oh_p1 <= win_oh;
      if (win_any) begin
        rom_row <= win_row;
        rom_col <= win_col;
        rom_sel <= win_sel;
      end else begin
        rom_row <= pl_hit ? pl_row : '0;
        rom_col <= pl_hit ? pl_col : '0;
        rom_sel <= (state == ST_DEAD) ? ROM_SEL_DEAD : '0;
      end
    end
  end

  assign btn_rise   = (|btn) & ~btn_any_q;
  assign frame_end  = (haddress == 10'd0) && (vaddress == 10'(V_ACTIVE));
  assign dead_clear = (state == ST_DEAD) && (debug || btn_rise);
  assign hit_p2     = vld_p1 & act_p1 & pl_in_p1 & ob_in_p1 & rom_pix_p & rom_pix_o;

  always_comb begin
    pix_c = 1'b0;
    if (vld_p1 && act_p1) begin
      if (state == ST_IDLE) pix_c = overlay_pix;
      else pix_c = (rom_pix_p & pl_in_p1) | (rom_pix_o & ob_in_p1) | overlay_pix;
    end
  end

  // Stage 2: composed pixel and collision record
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel   <= 1'b0;
      collide <= 1'b0;
      obj_hit <= '0;
    end else begin
      pixel <= pix_c;
      if (dead_clear) begin
        collide <= 1'b0;
        obj_hit <= '0;
      end else if (state == ST_RUN && hit_p2) begin
        collide <= 1'b1;
        obj_hit <= obj_hit | win_oh_p1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      btn_any_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      btn_any_q <= |btn;
    end
  end

  // Death is only committed at the frame boundary so a frame is never torn.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (|btn) state_nxt = ST_RUN;
      ST_RUN:  if (frame_end && collide) state_nxt = ST_DEAD;
      ST_DEAD: begin
        if (debug) state_nxt = ST_IDLE;
        else if (btn_rise) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_game_compositor.sv
// Randomized and directed bench for game_compositor against a behavioural
// screen/sprite/game-rule model.
module tb_game_compositor;
  import game_pkg::*;

  localparam int N_OBJ = 8;
  localparam int SPR_W = 32;
  localparam int SPR_H = 48;

  logic clk = 1'b0;
  logic reset;
  logic [9:0] haddress, vaddress, player_x, player_y;
  logic [3:0] btn;
  logic debug;
  logic [N_OBJ*10-1:0] obj_x, obj_y;
  logic [N_OBJ-1:0] obj_en;
  logic [5:0] rom_row;
  logic [4:0] rom_col, rom_sel;
  logic rom_pix_p, rom_pix_o, overlay_pix, pixel, collide;
  logic [1:0] game_state;
  logic [N_OBJ-1:0] obj_hit;
  logic rom_all_ones;

  int n_vec, n_bad;

  // model state
  int m_state, m_row, m_col, m_sel, m_win;
  bit m_collide, m_btn_prev, m_pin, m_oin, m_act, m_vld, m_pixel;
  bit [N_OBJ-1:0] m_hit;

  always #20 clk = ~clk;

  game_compositor #(.N_OBJ(N_OBJ), .SPR_W(SPR_W), .SPR_H(SPR_H)) dut (
    .clk(clk), .reset(reset), .haddress(haddress), .vaddress(vaddress),
    .btn(btn), .debug(debug), .player_x(player_x), .player_y(player_y),
    .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en),
    .rom_row(rom_row), .rom_col(rom_col), .rom_sel(rom_sel),
    .rom_pix_p(rom_pix_p), .rom_pix_o(rom_pix_o), .overlay_pix(overlay_pix),
    .pixel(pixel), .game_state(game_state), .collide(collide), .obj_hit(obj_hit)
  );

  function automatic bit rom_p_f(int row, int col, int sel);
    return ((row + col + sel) % 3) == 0;
  endfunction

  function automatic bit rom_o_f(int row, int col, int sel);
    return ((2 * row + col + sel) % 4) < 2;
  endfunction

  assign rom_pix_p = rom_all_ones | rom_p_f(int'(rom_row), int'(rom_col), int'(rom_sel));
  assign rom_pix_o = rom_all_ones | rom_o_f(int'(rom_row), int'(rom_col), int'(rom_sel));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_obj(input int k, input int x, input int y);
    obj_x[k*10 +: 10] = 10'(x);
    obj_y[k*10 +: 10] = 10'(y);
  endtask

  function automatic bit inside_box(int h, int v, int x, int y);
    return (h >= x) && (h < x + SPR_W) && (v >= y) && (v < y + SPR_H);
  endfunction

  task automatic model_reset();
    m_state = 0; m_collide = 0; m_hit = '0; m_btn_prev = 0;
    m_row = 0; m_col = 0; m_sel = 0; m_win = -1;
    m_pin = 0; m_oin = 0; m_act = 0; m_vld = 0; m_pixel = 0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_state"}, 32'(game_state), 0);
    check({pfx, "_collide"}, 32'(collide), 0);
    check({pfx, "_obj_hit"}, 32'(obj_hit), 0);
    check({pfx, "_pixel"}, 32'(pixel), 0);
    check({pfx, "_rom_row"}, 32'(rom_row), 0);
    check({pfx, "_rom_col"}, 32'(rom_col), 0);
    check({pfx, "_rom_sel"}, 32'(rom_sel), 0);
  endtask

  // One clock: predict from the inputs present before the edge, then compare.
  task automatic tick();
    int h, v, px, py, win, n_state, n_row, n_col, n_sel;
    bit rp, ro, coll, anyb, rise, n_collide, n_pixel, pin;
    bit [N_OBJ-1:0] n_hit;
    h = int'(haddress); v = int'(vaddress);
    px = int'(player_x); py = int'(player_y);

    rp = rom_all_ones || rom_p_f(m_row, m_col, m_sel);
    ro = rom_all_ones || rom_o_f(m_row, m_col, m_sel);
    if (!m_vld || !m_act) n_pixel = 0;
    else if (m_state == 0) n_pixel = overlay_pix;
    else n_pixel = (rp && m_pin) || (ro && m_oin) || overlay_pix;
    coll = m_vld && m_act && m_pin && m_oin && rp && ro;
    anyb = (btn != 0);
    rise = anyb && !m_btn_prev;

    n_state = m_state; n_collide = m_collide; n_hit = m_hit;
    case (m_state)
      0: if (anyb) n_state = 1;
      1: begin
        if (coll) begin n_collide = 1; n_hit[m_win] = 1'b1; end
        if (h == 0 && v == 480 && m_collide) n_state = 2;
      end
      default: begin
        if (debug) begin n_state = 0; n_collide = 0; n_hit = '0; end
        else if (rise) begin n_state = 1; n_collide = 0; n_hit = '0; end
      end
    endcase

    pin = inside_box(h, v, px, py);
    win = -1;
    for (int k = 0; k < N_OBJ; k++)
      if (win < 0 && obj_en[k] && inside_box(h, v, int'(obj_x[k*10 +: 10]), int'(obj_y[k*10 +: 10])))
        win = k;
    if (win >= 0) begin
      n_sel = win + 1;
      n_row = v - int'(obj_y[win*10 +: 10]);
      n_col = h - int'(obj_x[win*10 +: 10]);
    end else begin
      n_sel = (m_state == 2) ? 31 : 0;
      n_row = pin ? v - py : 0;
      n_col = pin ? h - px : 0;
    end

    @(posedge clk);
    #1;
    m_pixel = n_pixel; m_state = n_state; m_collide = n_collide; m_hit = n_hit;
    m_row = n_row; m_col = n_col; m_sel = n_sel; m_win = win;
    m_pin = pin; m_oin = (win >= 0); m_act = (h < 640) && (v < 480); m_vld = 1;
    m_btn_prev = anyb;

    check("rom_row", 32'(rom_row), 32'(m_row));
    check("rom_col", 32'(rom_col), 32'(m_col));
    check("rom_sel", 32'(rom_sel), 32'(m_sel));
    check("pixel", 32'(pixel), 32'(m_pixel));
    check("game_state", 32'(game_state), 32'(m_state));
    check("collide", 32'(collide), 32'(m_collide));
    check("obj_hit", 32'(obj_hit), 32'(m_hit));
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    reset = 1'b1;
    haddress = '0; vaddress = '0; btn = '0; debug = 1'b0;
    player_x = '0; player_y = '0; obj_en = '0; overlay_pix = 1'b0;
    obj_x = '1; obj_y = '1; rom_all_ones = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    // idle: only overlay shows, random scan
    for (int i = 0; i < 6; i++) begin
      haddress = 10'($urandom_range(0, 700));
      vaddress = 10'($urandom_range(0, 500));
      overlay_pix = 1'($urandom);
      tick();
    end

    // any button starts the game on the next clock
    btn = 4'b0001;
    tick();
    check("idle_to_run", 32'(game_state), 1);
    btn = 4'b0000;

    // player/obstacle overlap with solid sprites
    rom_all_ones = 1'b1; overlay_pix = 1'b0;
    player_x = 10'd200; player_y = 10'd200;
    set_obj(0, 210, 220); obj_en = 8'b0000_0001;
    haddress = 10'd215; vaddress = 10'd225;
    repeat (3) tick();
    check("collide_set", 32'(collide), 1);
    check("obj_hit0", 32'(obj_hit[0]), 1);
    haddress = 10'd0; vaddress = 10'd479;
    tick();
    check("no_mid_frame_death", 32'(game_state), 1);
    vaddress = 10'd480;
    tick();
    check("death_at_frame_end", 32'(game_state), 2);

    // debug beats a simultaneous button edge
    tick();
    debug = 1'b1; btn = 4'b0010;
    tick();
    check("debug_prio_state", 32'(game_state), 0);
    check("debug_prio_collide", 32'(collide), 0);
    debug = 1'b0; btn = 4'b0000;
    tick();

    // overlapping obstacles 2 and 5: channel 2 wins
    btn = 4'b0100;
    tick();
    btn = 4'b0000;
    obj_en = 8'b0010_0100;
    set_obj(2, 300, 300); set_obj(5, 300, 300);
    player_x = 10'd300; player_y = 10'd300;
    haddress = 10'd305; vaddress = 10'd305;
    tick();
    check("overlap_sel", 32'(rom_sel), 3);
    repeat (2) tick();
    check("overlap_hit", 32'(obj_hit), 32'h04);

    // right edge of screen and no wrap into column 0
    obj_en = 8'b0000_0001; set_obj(0, 600, 100);
    player_x = 10'd1000; player_y = 10'd1000;
    vaddress = 10'd110; haddress = 10'd610;
    repeat (2) tick();
    check("edge_inside", 32'(pixel), 1);
    haddress = 10'd640;
    repeat (2) tick();
    check("edge_640", 32'(pixel), 0);
    for (int h = 0; h < 32; h++) begin
      haddress = 10'(h);
      repeat (2) tick();
      check("no_wrap", 32'(pixel), 0);
    end

    // randomized play
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        rom_all_ones = ($urandom_range(0, 3) == 0);
        player_x = 10'($urandom_range(80, 180));
        player_y = 10'($urandom_range(80, 180));
        for (int k = 0; k < N_OBJ; k++)
          set_obj(k, $urandom_range(60, 220), $urandom_range(60, 220));
        obj_en = N_OBJ'($urandom);
      end
      if ($urandom_range(0, 49) == 0) begin
        haddress = 10'd0; vaddress = 10'd480;
      end else if ($urandom_range(0, 4) != 0) begin
        haddress = 10'($urandom_range(60, 250));
        vaddress = 10'($urandom_range(60, 250));
      end else begin
        haddress = 10'($urandom_range(0, 1023));
        vaddress = 10'($urandom_range(0, 1023));
      end
      btn = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      debug = ($urandom_range(0, 99) == 0);
      overlay_pix = ($urandom_range(0, 7) == 0);
      tick();
    end

    // reset in the middle of a line while running
    btn = 4'b0000; debug = 1'b1; haddress = 10'd100; vaddress = 10'd100;
    tick();
    debug = 1'b0; btn = 4'b1000;
    tick();
    btn = 4'b0000;
    rom_all_ones = 1'b1; overlay_pix = 1'b1;
    repeat (3) tick();
    check("pre_reset_run", 32'(game_state), 1);
    #5 reset = 1'b1;
    #1;
    check_all_zero("midline_rst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      haddress = 10'($urandom_range(0, 700));
      vaddress = 10'($urandom_range(0, 500));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
